spatz_vrf_rd_fetch: RTL and testbench
=====================================

SPATZ_VRF_RD_FETCH -- requirements
Module: spatz_vrf_rd_fetch

Interface
REQ-001 SHALL have parameter Depth, default 2, operand FIFO depth in words (legal range 2..8).
REQ-002 SHALL have parameter LenWidth, default 8, width of the request length field.
REQ-003 SHALL have port clk_i input 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_ni input 1, asynchronous active-low reset.
REQ-005 SHALL have port req_valid_i input 1, fetch request valid.
REQ-006 SHALL have port req_ready_o output 1, fetch request accepted when high together with req_valid_i.
REQ-007 SHALL have port req_addr_i input vreg_addr_t, address of the first word.
REQ-008 SHALL have port req_len_i input LenWidth, number of words minus one.
REQ-009 SHALL have port flush_i input 1, synchronous abort.
REQ-010 SHALL have port vrf_raddr_o output vreg_addr_t, read address to one register-file read port.
REQ-011 SHALL have port vrf_re_o output 1, read enable to that port.
REQ-012 SHALL have port vrf_rdata_i input vreg_data_t, read data, same-cycle.
REQ-013 SHALL have port vrf_rvalid_i input 1, read granted this cycle (may be low because of bank arbitration).
REQ-014 SHALL have port data_o output vreg_data_t, operand word to the consumer.
REQ-015 SHALL have port data_last_o output 1, marks the final word of a request.
REQ-016 SHALL have port data_valid_o output 1 and data_ready_i input 1, the consumer handshake.
REQ-017 SHALL have port busy_o output 1, high in FETCH or while the FIFO is non-empty.

Function
REQ-018 SHALL implement states IDLE and FETCH.
REQ-019 IDLE: req_ready_o=1; on req_valid_i, latch addr=req_addr_i and remaining=req_len_i, then go to FETCH next cycle.
REQ-020 FETCH: req_ready_o=0; vrf_re_o=1 only when the FIFO has at least one free entry after any same-cycle pop; vrf_raddr_o=current addr.
REQ-021 On vrf_re_o & vrf_rvalid_i, SHALL push vrf_rdata_i into the FIFO in the same cycle, with last=(remaining==0).
REQ-022 On a granted read with remaining!=0: addr increments by 1 (wraps modulo 2^$bits(vreg_addr_t)) and remaining decrements by 1.
REQ-023 On a granted read with remaining==0: SHALL return to IDLE next cycle.
REQ-024 vrf_re_o & !vrf_rvalid_i: no push and no address change; the same address is retried next cycle.
REQ-025 The FIFO SHALL be first-word fall-through: data_valid_o=!empty; a pop occurs on data_valid_o & data_ready_i.
REQ-026 Simultaneous push and pop with the FIFO full SHALL be legal and SHALL keep the occupancy constant.
REQ-027 Data SHALL never be dropped or duplicated; FIFO order SHALL equal address order.
REQ-028 A new request MAY be accepted in IDLE while older words remain in the FIFO; words of both requests SHALL stay in order.
REQ-029 flush_i SHALL take priority over all events: the FIFO empties, the state goes to IDLE, and vrf_re_o=0 in the flush cycle.
REQ-030 flush_i SHALL NOT accept a request in the flush cycle (req_ready_o=0).
REQ-031 Latency: the first word reaches data_o 2 cycles after request acceptance when rvalid is granted and the FIFO is empty (accept, issue, visible).

Reset
REQ-032 While rst_ni=0, asynchronously: state=IDLE, FIFO empty, addr=0, remaining=0.
REQ-033 During reset, outputs SHALL be: req_ready_o=1, vrf_re_o=0, vrf_raddr_o=0, data_valid_o=0, data_last_o=0, busy_o=0, data_o=0.
REQ-034 Reset asserted mid-fetch SHALL discard all buffered words; no read SHALL be issued in the first cycle after release.

Verification
REQ-035 Single word: addr=0x05, len=0, rvalid=1, ready=1 -> one read of 0x05; data_o valid 2 cycles after accept with last=1; then IDLE.
REQ-036 Burst: addr=0x10, len=3, rvalid=1 -> reads 0x10..0x13 on consecutive cycles; last=1 only on word 4.
REQ-037 Arbitration loss: len=1, rvalid low for 3 cycles on the first read -> 0x20 is held for 4 cycles, then 0x21 is read; exactly 2 words are delivered.
REQ-038 Backpressure: Depth=2, len=4, ready=0 -> exactly 2 reads granted, then vrf_re_o=0; after ready=1 the remaining 3 words follow in order.
REQ-039 Wrap: addr=all-ones, len=1 -> reads all-ones then 0.
REQ-040 Flush mid-burst: len=7, flush after 3 words with FIFO non-empty -> next cycle data_valid_o=0, state IDLE, no further reads, next request served normally.

Source files
------------

// File: rtl/spatz_vrf_rd_fetch.sv
// Operand fetch unit: walks a range of vector-register words through one VRF
// read port and buffers them in a small first-word-fall-through FIFO.
module spatz_vrf_rd_fetch #(
  parameter int unsigned Depth     = 2,
  parameter int unsigned LenWidth  = 8,
  parameter int unsigned AddrWidth = 8,
  parameter int unsigned DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic [LenWidth-1:0]  req_len_i,
  input  logic                 flush_i,
  output logic [AddrWidth-1:0] vrf_raddr_o,
  output logic                 vrf_re_o,
  input  logic [DataWidth-1:0] vrf_rdata_i,
  input  logic                 vrf_rvalid_i,
  output logic [DataWidth-1:0] data_o,
  output logic                 data_last_o,
  output logic                 data_valid_o,
  input  logic                 data_ready_i,
  output logic                 busy_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(Depth);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } state_e;

  state_e               r_state, w_state_nxt;
  logic [AddrWidth-1:0] r_addr, w_addr_nxt;
  logic [LenWidth-1:0]  r_rem, w_rem_nxt;

  logic [DataWidth-1:0] r_mem_data [Depth];
  logic                 r_mem_last [Depth];
  logic [PtrW-1:0]      r_wr_ptr, r_rd_ptr;
  logic [CntW-1:0]      r_count;

  logic w_empty, w_pop, w_push, w_space, w_push_last;

  assign w_empty      = (r_count == {CntW{1'b0}});
  assign data_valid_o = ~w_empty;
  assign w_pop        = data_valid_o & data_ready_i;
  // A slot freed by this cycle's pop may be refilled in the same cycle.
  assign w_space      = (r_count != FullCnt) | w_pop;
  assign w_push       = vrf_re_o & vrf_rvalid_i;
  assign vrf_raddr_o  = r_addr;
  assign busy_o       = (r_state == FETCH) | ~w_empty;

  // Output word: driven to zero whenever the FIFO holds nothing.
  always_comb begin
    data_o      = {DataWidth{1'b0}};
    data_last_o = 1'b0;
    if (!w_empty) begin
      data_o      = r_mem_data[r_rd_ptr];
      data_last_o = r_mem_last[r_rd_ptr];
    end else begin
      data_o      = {DataWidth{1'b0}};
      data_last_o = 1'b0;
    end
  end

  // Next-state, request handshake and read-port control.
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_rem_nxt   = r_rem;
    req_ready_o = 1'b0;
    vrf_re_o    = 1'b0;
    w_push_last = 1'b0;
    if (flush_i) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          req_ready_o = 1'b1;
          if (req_valid_i) begin
            w_addr_nxt  = req_addr_i;
            w_rem_nxt   = req_len_i;
            w_state_nxt = FETCH;
          end else begin
            w_state_nxt = IDLE;
          end
        end
        FETCH: begin
          vrf_re_o    = w_space;
          w_push_last = (r_rem == {LenWidth{1'b0}});
          if (w_space && vrf_rvalid_i) begin
            if (r_rem == {LenWidth{1'b0}}) begin
              w_state_nxt = IDLE;
            end else begin
              w_addr_nxt = r_addr + AddrWidth'(1);
              w_rem_nxt  = r_rem - LenWidth'(1);
            end
          end else begin
            w_state_nxt = FETCH;
          end
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  // FSM state, address and remaining-count registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_addr  <= {AddrWidth{1'b0}};
      r_rem   <= {LenWidth{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_rem   <= w_rem_nxt;
    end
  end

  // Operand FIFO storage, pointers and occupancy; flush drops every entry.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) begin
        r_mem_data[i] <= {DataWidth{1'b0}};
        r_mem_last[i] <= 1'b0;
      end
      r_wr_ptr <= {PtrW{1'b0}};
      r_rd_ptr <= {PtrW{1'b0}};
      r_count  <= {CntW{1'b0}};
    end else if (flush_i) begin
      r_wr_ptr <= {PtrW{1'b0}};
      r_rd_ptr <= {PtrW{1'b0}};
      r_count  <= {CntW{1'b0}};
    end else begin
      if (w_push) begin
        r_mem_data[r_wr_ptr] <= vrf_rdata_i;
        r_mem_last[r_wr_ptr] <= w_push_last;
        r_wr_ptr <= (r_wr_ptr == LastPtr) ? {PtrW{1'b0}} : r_wr_ptr + PtrW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == LastPtr) ? {PtrW{1'b0}} : r_rd_ptr + PtrW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_spatz_vrf_rd_fetch.sv
// Scoreboard bench for spatz_vrf_rd_fetch: directed requests push expected read
// addresses and operand words; two monitors pop and compare on DUT handshakes.
module tb_spatz_vrf_rd_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [7:0]  req_addr;
  logic [7:0]  req_len;
  logic        flush;
  logic [7:0]  vrf_raddr;
  logic        vrf_re;
  logic [31:0] vrf_rdata;
  logic        vrf_rvalid;
  logic [31:0] data;
  logic        data_last, data_valid, data_ready, busy;

  int n_vec = 0;
  int n_err = 0;
  int grant_cnt = 0;

  logic [7:0]  exp_addr [$];
  logic [31:0] exp_data [$];
  logic        exp_last [$];

  always #5 clk = ~clk;

  function automatic logic [31:0] mk_data(input logic [7:0] a);
    return {a, ~a, a ^ 8'h5A, 8'hC3};
  endfunction

  assign vrf_rdata = mk_data(vrf_raddr);

  spatz_vrf_rd_fetch #(.Depth(2), .LenWidth(8), .AddrWidth(8), .DataWidth(32)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_addr_i(req_addr), .req_len_i(req_len), .flush_i(flush),
    .vrf_raddr_o(vrf_raddr), .vrf_re_o(vrf_re),
    .vrf_rdata_i(vrf_rdata), .vrf_rvalid_i(vrf_rvalid),
    .data_o(data), .data_last_o(data_last), .data_valid_o(data_valid),
    .data_ready_i(data_ready), .busy_o(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Read-port monitor: every granted read must match the next expected address.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && vrf_re === 1'b1 && vrf_rvalid === 1'b1) begin
      grant_cnt++;
      if (exp_addr.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL rd_unexpected: read of %h, expected no read", vrf_raddr);
      end else begin
        chk("rd_addr", {24'h0, vrf_raddr}, {24'h0, exp_addr.pop_front()});
      end
    end
  end

  // Consumer monitor: every accepted operand word must match the scoreboard.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && data_valid === 1'b1 && data_ready === 1'b1) begin
      if (exp_data.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL data_unexpected: word %h, expected none", data);
      end else begin
        chk("data_word", data, exp_data.pop_front());
        chk("data_last", {31'h0, data_last}, {31'h0, exp_last.pop_front()});
      end
    end
  end

  task automatic issue_req(input logic [7:0] a, input logic [7:0] len,
                           input int n_rd, input int n_dat);
    logic acc, acc_now;
    logic [7:0] ad;
    for (int i = 0; i < n_rd; i++) begin
      ad = a + 8'(i);
      exp_addr.push_back(ad);
    end
    for (int i = 0; i < n_dat; i++) begin
      ad = a + 8'(i);
      exp_data.push_back(mk_data(ad));
      exp_last.push_back(i == int'(len));
    end
    req_addr  = a;
    req_len   = len;
    req_valid = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      acc_now = req_ready;
      @(posedge clk);
      #1;
      if (acc_now) begin
        acc = 1'b1;
        break;
      end
    end
    req_valid = 1'b0;
    chk("req_accept", {31'h0, acc}, 32'h1);
  endtask

  task automatic wait_idle();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy && exp_data.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    chk("idle_timeout", {31'h0, done}, 32'h1);
    chk("rd_left", exp_addr.size(), 32'h0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_addr = 8'h00; req_len = 8'h00;
    flush = 1'b0; vrf_rvalid = 1'b1; data_ready = 1'b1;
    #3;
    chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_re", {31'h0, vrf_re}, 32'h0);
    chk("rst_raddr", {24'h0, vrf_raddr}, 32'h0);
    chk("rst_dvalid", {31'h0, data_valid}, 32'h0);
    chk("rst_last", {31'h0, data_last}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_data", data, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single word: read issued in the cycle after accept, visible the one after.
    issue_req(8'h05, 8'h00, 1, 1);
    @(negedge clk);
    chk("single_re", {31'h0, vrf_re}, 32'h1);
    chk("single_raddr", {24'h0, vrf_raddr}, 32'h05);
    chk("single_dvalid_early", {31'h0, data_valid}, 32'h0);
    @(negedge clk);
    chk("single_dvalid", {31'h0, data_valid}, 32'h1);
    chk("single_data", data, mk_data(8'h05));
    chk("single_last", {31'h0, data_last}, 32'h1);
    chk("single_idle", {31'h0, req_ready}, 32'h1);
    wait_idle();

    // Burst of four on consecutive cycles.
    issue_req(8'h10, 8'h03, 4, 4);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("burst_re", {31'h0, vrf_re}, 32'h1);
      chk("burst_raddr", {24'h0, vrf_raddr}, 32'h10 + i);
      @(posedge clk);
      #1;
    end
    wait_idle();

    // Arbitration loss: first address held for four cycles.
    vrf_rvalid = 1'b0;
    issue_req(8'h20, 8'h01, 2, 2);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("arb_hold_re", {31'h0, vrf_re}, 32'h1);
      chk("arb_hold_addr", {24'h0, vrf_raddr}, 32'h20);
      @(posedge clk);
      #1;
    end
    vrf_rvalid = 1'b1;
    @(negedge clk);
    chk("arb_grant_addr", {24'h0, vrf_raddr}, 32'h20);
    wait_idle();

    // Backpressure: two-entry FIFO fills, then reads stop.
    data_ready = 1'b0;
    grant_cnt = 0;
    issue_req(8'h30, 8'h04, 5, 5);
    repeat (6) @(negedge clk);
    chk("bp_grants", grant_cnt, 32'h2);
    chk("bp_re_off", {31'h0, vrf_re}, 32'h0);
    chk("bp_busy", {31'h0, busy}, 32'h1);
    @(posedge clk);
    #1 data_ready = 1'b1;
    wait_idle();

    // Wrap-around of the read address.
    issue_req(8'hFF, 8'h01, 2, 2);
    wait_idle();

    // Second request accepted while the first one's words are still buffered.
    data_ready = 1'b0;
    issue_req(8'h50, 8'h01, 2, 2);
    issue_req(8'h58, 8'h01, 2, 2);
    @(negedge clk);
    chk("b2b_full_re", {31'h0, vrf_re}, 32'h0);
    @(posedge clk);
    #1 data_ready = 1'b1;
    wait_idle();

    // Flush mid-burst with the FIFO holding word 0x42.
    issue_req(8'h40, 8'h07, 3, 2);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    flush = 1'b1;
    data_ready = 1'b0;
    @(negedge clk);
    chk("flush_re", {31'h0, vrf_re}, 32'h0);
    chk("flush_req_ready", {31'h0, req_ready}, 32'h0);
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("post_flush_dvalid", {31'h0, data_valid}, 32'h0);
    chk("post_flush_busy", {31'h0, busy}, 32'h0);
    chk("post_flush_idle", {31'h0, req_ready}, 32'h1);
    @(posedge clk);
    #1 data_ready = 1'b1;
    wait_idle();
    issue_req(8'h48, 8'h01, 2, 2);
    wait_idle();

    // Reset in the middle of a fetch discards buffered words.
    data_ready = 1'b0;
    issue_req(8'h60, 8'h05, 2, 0);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #2;
    chk("mid_rst_dvalid", {31'h0, data_valid}, 32'h0);
    chk("mid_rst_busy", {31'h0, busy}, 32'h0);
    chk("mid_rst_raddr", {24'h0, vrf_raddr}, 32'h0);
    exp_addr.delete();
    exp_data.delete();
    exp_last.delete();
    data_ready = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_re", {31'h0, vrf_re}, 32'h0);
    chk("post_rst_dvalid", {31'h0, data_valid}, 32'h0);
    @(posedge clk);
    #1;
    issue_req(8'h70, 8'h02, 3, 3);
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
